div_unit: RTL

- Multi-cycle radix-2 restoring divider in the EX stage.
- Consumes DIV_CONTROL/DIVU_CONTROL operations selected by the ALU control decode.
- Produces the {HI, LO} = {remainder, quotient} pair written to the HI/LO registers.
- The EX stage stalls the pipeline while the divider is busy; operands come from the forwarded rs/rt values.

---
 rtl/div_unit.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// ============================================================================
//  Module   : div_unit
//  Purpose  : Multi-cycle radix-2 restoring divider (DIV/DIVU) for EX stage,
//             producing {remainder, quotient} for the HI/LO registers.
//  Revision : 1.0  - initial release
// ============================================================================
`default_nettype none

module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_div,
    input  logic [WIDTH-1:0]     opdata_a,
    input  logic [WIDTH-1:0]     opdata_b,
    input  logic                 annul,
    output logic [2*WIDTH-1:0]   result,
    output logic                 ready,
    output logic                 busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DIVZERO = 2'd1,
        S_ON      = 2'd2,
        S_END     = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_divisor;
    logic               r_sign_q;
    logic               r_sign_r;
    logic [2*WIDTH-1:0] r_result;
    logic               r_ready;

    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic [WIDTH-1:0]   w_rem_nxt;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic               w_last;

    assign w_a_mag = (signed_div && opdata_a[WIDTH-1]) ? (WIDTH'(0) - opdata_a) : opdata_a;
    assign w_b_mag = (signed_div && opdata_b[WIDTH-1]) ? (WIDTH'(0) - opdata_b) : opdata_b;

    // The quotient register doubles as the dividend shifter: its MSB feeds the
    // partial remainder while the new quotient bit enters at the LSB.
    assign w_shift   = {r_rem, r_quo[WIDTH-1]};
    assign w_diff    = {1'b0, w_shift[WIDTH-1:0]} - {1'b0, r_divisor};
    assign w_ge      = w_shift[WIDTH] | ~w_diff[WIDTH];
    assign w_rem_nxt = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quo_fix = r_sign_q ? (WIDTH'(0) - r_quo) : r_quo;
    assign w_rem_fix = r_sign_r ? (WIDTH'(0) - r_rem) : r_rem;
    assign w_last    = (r_cnt == CNT_W'(WIDTH));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start && !annul) begin
                    w_next = (opdata_b == '0) ? S_DIVZERO : S_ON;
                end
            end
            S_DIVZERO: w_next = annul ? S_IDLE : S_END;
            S_ON: begin
                if (annul) begin
                    w_next = S_IDLE;
                end else if (w_last) begin
                    w_next = S_END;
                end
            end
            S_END: begin
                if (annul || !start) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_sign_q  <= 1'b0;
            r_sign_r  <= 1'b0;
            r_result  <= '0;
            r_ready   <= 1'b0;
        end else if (annul && (r_state != S_IDLE)) begin
            r_cnt    <= '0;
            r_result <= '0;
            r_ready  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && !annul) begin
                        r_quo     <= w_a_mag;
                        r_divisor <= w_b_mag;
                        r_rem     <= '0;
                        r_cnt     <= '0;
                        r_sign_q  <= signed_div & (opdata_a[WIDTH-1] ^ opdata_b[WIDTH-1]);
                        r_sign_r  <= signed_div & opdata_a[WIDTH-1];
                    end
                end
                S_DIVZERO: begin
                    r_result <= '0;
                    r_ready  <= 1'b1;
                end
                S_ON: begin
                    if (w_last) begin
                        r_result <= {w_rem_fix, w_quo_fix};
                        r_ready  <= 1'b1;
                    end else begin
                        r_rem <= w_rem_nxt;
                        r_quo <= {r_quo[WIDTH-2:0], w_ge};
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_END: begin
                    if (!start) begin
                        r_cnt    <= '0;
                        r_result <= '0;
                        r_ready  <= 1'b0;
                    end
                end
                default: begin
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign result = r_result;
    assign ready  = r_ready;
    assign busy   = (r_state != S_IDLE);

endmodule

`default_nettype wire
